// File: rtl/nios2_debug_ocimem_arbiter.sv
// Arbitrates the single-port OCIRAM between JTAG debug command strobes and the
// Avalon debug_mem slave, with JTAG address auto-increment and round-robin on conflict.
module nios2_debug_ocimem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned BE_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              jtag_load_addr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_access,
  input  logic              jtag_wr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_done,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  input  logic [BE_W-1:0]   av_byteenable,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [BE_W-1:0]   ram_byteen,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AV_RD = 2'd1,
    S_JT_RD = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                jtag_pend;
  logic                jwr;
  logic [DATA_W-1:0]   jwdata;
  logic [ADDR_W-1:0]   jaddr;
  logic                last_grant_jt;
  logic                av_req;
  logic                grant_av;
  logic                grant_jt;
  logic                jt_complete;
  logic                jt_drop;

  // Grants only issue from IDLE and never while reset is asserted
  always_comb begin
    av_req   = av_read | av_write;
    grant_av = 1'b0;
    grant_jt = 1'b0;
    if (reset_n && (state == S_IDLE)) begin
      if (jtag_pend && (!av_req || !last_grant_jt)) begin
        grant_jt = 1'b1;
      end else if (av_req) begin
        grant_av = 1'b1;
      end
    end
  end

  assign jt_complete = (state == S_JT_RD) || (grant_jt && jwr);
  assign jt_drop     = jtag_access && (jtag_pend || jtag_load_addr);

  // Next state and RAM/Avalon drive
  always_comb begin
    state_nxt      = state;
    ram_addr       = '0;
    ram_wren       = 1'b0;
    ram_byteen     = '0;
    ram_wdata      = '0;
    av_waitrequest = av_req;
    av_readdata    = '0;
    case (state)
      S_IDLE: begin
        if (grant_jt) begin
          ram_addr = jaddr;
          if (jwr) begin
            ram_wren   = 1'b1;
            ram_byteen = '1;
            ram_wdata  = jwdata;
          end else begin
            state_nxt = S_JT_RD;
          end
        end else if (grant_av) begin
          ram_addr = av_address;
          if (av_read) begin
            state_nxt = S_AV_RD;
          end else begin
            ram_wren       = 1'b1;
            ram_byteen     = av_byteenable;
            ram_wdata      = av_writedata;
            av_waitrequest = 1'b0;
          end
        end
      end
      S_AV_RD: begin
        av_readdata    = ram_rdata;
        av_waitrequest = 1'b0;
        state_nxt      = S_IDLE;
      end
      S_JT_RD: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      jtag_pend     <= 1'b0;
      jwr           <= 1'b0;
      jwdata        <= '0;
      jaddr         <= '0;
      last_grant_jt <= 1'b0;
      jtag_rdata    <= '0;
      jtag_done     <= 1'b0;
      jtag_overrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      jtag_done <= jt_complete;
      if (grant_jt) begin
        last_grant_jt <= 1'b1;
      end else if (grant_av) begin
        last_grant_jt <= 1'b0;
      end
      if (state == S_JT_RD) begin
        jtag_rdata <= ram_rdata;
      end
      // A strobe arriving while one is pending (or alongside a load) is lost
      if (jtag_access && !jt_drop) begin
        jtag_pend <= 1'b1;
        jwr       <= jtag_wr;
        jwdata    <= jtag_wdata;
      end else if (jt_complete) begin
        jtag_pend <= 1'b0;
      end
      if (jt_drop) begin
        jtag_overrun <= 1'b1;
      end else if (jtag_load_addr) begin
        jtag_overrun <= 1'b0;
      end
      if (jtag_load_addr && !jtag_pend) begin
        jaddr <= jtag_addr;
      end else if (jt_complete) begin
        jaddr <= jaddr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_nios2_debug_ocimem_arbiter.sv
// Bench for nios2_debug_ocimem_arbiter: directed arbitration/timing steps plus
// randomized traffic checked against a shadow memory and a JTAG pointer model.
module tb_nios2_debug_ocimem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        jtag_load_addr;
  logic [7:0]  jtag_addr;
  logic        jtag_access;
  logic        jtag_wr;
  logic [31:0] jtag_wdata;
  logic [31:0] jtag_rdata;
  logic        jtag_done;
  logic        jtag_overrun;
  logic [7:0]  av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem    [256] = '{default: '0};
  logic [31:0] shadow [256] = '{default: '0};
  logic [7:0]  jptr;
  int          tests = 0;
  int          fails = 0;

  nios2_debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .jtag_load_addr(jtag_load_addr), .jtag_addr(jtag_addr),
    .jtag_access(jtag_access), .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata),
    .jtag_rdata(jtag_rdata), .jtag_done(jtag_done), .jtag_overrun(jtag_overrun),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable),
    .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port OCIRAM with one-cycle read latency
  always @(posedge clk) begin
    if (ram_wren)
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic shadow_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic jt_load(input logic [7:0] a);
    jtag_load_addr = 1'b1;
    jtag_addr      = a;
    cyc();
    jtag_load_addr = 1'b0;
    jptr           = a;
  endtask

  // One JTAG access; strict = no competing Avalon traffic so timing is exact
  task automatic jt_op(input bit wr, input logic [31:0] wd, input bit strict);
    bit got;
    int lat;
    jtag_access = 1'b1;
    jtag_wr     = wr;
    jtag_wdata  = wd;
    cyc();
    jtag_access = 1'b0;
    got = 0;
    lat = 0;
    for (int n = 1; n < 20; n++) begin
      #2;
      if (n == 1 && strict) begin
        chk("jt_grant_addr", ram_addr, jptr);
        chk("jt_grant_wren", ram_wren, wr);
      end
      if (jtag_done) begin
        got = 1;
        lat = n;
        break;
      end
      cyc();
    end
    chk("jt_done_seen", got, 1);
    if (strict) chk("jt_latency", lat, wr ? 2 : 3);
    if (wr) shadow[jptr] = wd;
    else    chk("jt_rdata", jtag_rdata, shadow[jptr]);
    jptr = jptr + 8'd1;
    cyc();
  endtask

  task automatic av_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, input bit strict);
    bit got;
    int lat;
    av_write = 1'b1; av_read = 1'b0; av_address = a; av_writedata = d; av_byteenable = be;
    got = 0;
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      #2;
      if (!av_waitrequest) begin
        got = 1;
        lat = n + 1;
        break;
      end
      cyc();
    end
    if (got) cyc();
    av_write = 1'b0;
    chk("av_wr_done", got, 1);
    if (strict) chk("av_wr_latency", lat, 1);
    shadow_wr(a, d, be);
  endtask

  task automatic av_rd(input logic [7:0] a, input bit strict, input bit also_wr);
    bit got;
    int lat;
    logic [31:0] rd;
    av_read = 1'b1; av_write = also_wr; av_address = a;
    av_writedata = $urandom; av_byteenable = 4'hF;
    got = 0;
    lat = 0;
    rd  = '0;
    for (int n = 0; n < 20; n++) begin
      #2;
      if (n == 0 && strict) begin
        chk("av_rd_addr", ram_addr, a);
        chk("av_rd_wren", ram_wren, 0);
      end
      if (!av_waitrequest) begin
        got = 1;
        lat = n + 1;
        rd  = av_readdata;
        break;
      end
      cyc();
    end
    if (got) cyc();
    av_read = 1'b0; av_write = 1'b0;
    chk("av_rd_done", got, 1);
    if (strict) chk("av_rd_latency", lat, 2);
    chk("av_rd_data", rd, shadow[a]);
  endtask

  initial begin
    int dcount;
    logic [7:0]  ra;
    logic [31:0] rd;
    reset_n = 1'b0;
    jtag_load_addr = 1'b0; jtag_addr = '0; jtag_access = 1'b0; jtag_wr = 1'b0; jtag_wdata = '0;
    av_address = '0; av_read = 1'b1; av_write = 1'b0; av_writedata = '0; av_byteenable = '0;
    jptr = '0;

    // Reset state
    #3;
    chk("rst_waitreq", av_waitrequest, 1);
    chk("rst_wren", ram_wren, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_done", jtag_done, 0);
    chk("rst_overrun", jtag_overrun, 0);
    chk("rst_readdata", av_readdata, 0);
    cyc(); cyc();
    av_read = 1'b0;
    reset_n = 1'b1;
    cyc();

    // First conflict after reset goes to JTAG, Avalon next
    jtag_access = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'h1111_0001;
    cyc();
    jtag_access = 1'b0;
    av_write = 1'b1; av_address = 8'h40; av_writedata = 32'hA0A0_0040; av_byteenable = 4'hF;
    #2;
    chk("c1_jt_addr", ram_addr, 8'h00);
    chk("c1_jt_wdata", ram_wdata, 32'h1111_0001);
    chk("c1_jt_byteen", ram_byteen, 4'hF);
    chk("c1_av_wait", av_waitrequest, 1);
    cyc(); #2;
    chk("c1_jt_done", jtag_done, 1);
    chk("c1_av_addr", ram_addr, 8'h40);
    chk("c1_av_wren", ram_wren, 1);
    chk("c1_av_wait2", av_waitrequest, 0);
    cyc();
    av_write = 1'b0;
    shadow[8'h00] = 32'h1111_0001;
    shadow[8'h40] = 32'hA0A0_0040;
    jptr = 8'h01;
    jt_op(1'b1, 32'h2222_0002, 1'b1);

    // After a JTAG grant the next conflict goes to Avalon
    jtag_access = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'h3333_0003;
    cyc();
    jtag_access = 1'b0;
    av_write = 1'b1; av_address = 8'h41; av_writedata = 32'hB0B0_0041; av_byteenable = 4'hF;
    #2;
    chk("c2_av_addr", ram_addr, 8'h41);
    chk("c2_av_wdata", ram_wdata, 32'hB0B0_0041);
    chk("c2_av_wait", av_waitrequest, 0);
    cyc();
    av_write = 1'b0;
    #2;
    chk("c2_jt_addr", ram_addr, 8'h02);
    chk("c2_jt_wren", ram_wren, 1);
    cyc(); #2;
    chk("c2_jt_done", jtag_done, 1);
    cyc();
    shadow[8'h02] = 32'h3333_0003;
    shadow[8'h41] = 32'hB0B0_0041;
    jptr = 8'h03;
    av_rd(8'h00, 1'b1, 1'b0);
    av_rd(8'h01, 1'b1, 1'b0);
    av_rd(8'h02, 1'b1, 1'b0);
    av_rd(8'h40, 1'b1, 1'b0);
    av_rd(8'h41, 1'b1, 1'b0);

    // JTAG write then read with auto-increment
    jt_load(8'h10);
    jt_op(1'b1, 32'hDEAD_BEEF, 1'b1);
    jt_op(1'b0, 32'h0, 1'b1);
    jt_load(8'h10);
    jt_op(1'b0, 32'h0, 1'b1);
    chk("t1_rdata_hold", jtag_rdata, 32'hDEAD_BEEF);

    // Avalon read latency, and read+write treated as read
    av_wr(8'h05, 32'h1234_5678, 4'hF, 1'b1);
    av_rd(8'h05, 1'b1, 1'b0);
    av_rd(8'h05, 1'b1, 1'b1);
    av_rd(8'h05, 1'b1, 1'b0);
    av_wr(8'h06, 32'hCAFE_F00D, 4'b0101, 1'b1);
    av_rd(8'h06, 1'b1, 1'b0);

    // Address wrap
    jt_load(8'hFF);
    jt_op(1'b0, 32'h0, 1'b1);
    jt_op(1'b0, 32'h0, 1'b1);

    // Overrun: strobe while pending is dropped, load clears the flag
    jt_load(8'h20);
    chk("ovr_clear0", jtag_overrun, 0);
    jtag_access = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'hA5A5_A5A5;
    cyc();
    jtag_wdata = 32'h5A5A_5A5A;
    #2;
    chk("ovr_first_data", ram_wdata, 32'hA5A5_A5A5);
    cyc();
    jtag_access = 1'b0;
    #2;
    chk("ovr_set", jtag_overrun, 1);
    chk("ovr_done", jtag_done, 1);
    cyc();
    dcount = 0;
    for (int n = 0; n < 5; n++) begin
      #2;
      if (jtag_done) dcount++;
      cyc();
    end
    chk("ovr_single_access", dcount, 0);
    shadow[8'h20] = 32'hA5A5_A5A5;
    jptr = 8'h21;
    jt_op(1'b0, 32'h0, 1'b1);
    chk("ovr_sticky", jtag_overrun, 1);
    jt_load(8'h20);
    #2;
    chk("ovr_cleared", jtag_overrun, 0);
    jt_op(1'b0, 32'h0, 1'b1);
    // Coinciding load and access: access dropped, load applies
    jtag_load_addr = 1'b1; jtag_addr = 8'h30; jtag_access = 1'b1; jtag_wr = 1'b1;
    cyc();
    jtag_load_addr = 1'b0; jtag_access = 1'b0;
    #2;
    chk("coin_overrun", jtag_overrun, 1);
    chk("coin_no_grant", ram_wren, 0);
    cyc();
    jptr = 8'h30;
    jt_op(1'b0, 32'h0, 1'b1);

    // Reset during JT_RD aborts silently
    jt_load(8'h10);
    jtag_access = 1'b1; jtag_wr = 1'b0;
    cyc();
    jtag_access = 1'b0;
    #2;
    chk("r6_grant_addr", ram_addr, 8'h10);
    cyc();
    reset_n = 1'b0;
    #2;
    chk("r6_done", jtag_done, 0);
    chk("r6_rdata", jtag_rdata, 0);
    chk("r6_overrun", jtag_overrun, 0);
    chk("r6_addr", ram_addr, 0);
    chk("r6_wait", av_waitrequest, 0);
    chk("r6_byteen", ram_byteen, 0);
    cyc(); cyc();
    reset_n = 1'b1;
    jptr = 8'h00;
    dcount = 0;
    for (int n = 0; n < 4; n++) begin
      #2;
      if (jtag_done) dcount++;
      cyc();
    end
    chk("r6_no_done", dcount, 0);
    av_rd(8'h10, 1'b1, 1'b0);
    jt_op(1'b0, 32'h0, 1'b1);

    // Randomized serialized traffic against the shadow memory
    for (int i = 0; i < 80; i++) begin
      ra = 8'($urandom);
      rd = $urandom;
      case ($urandom_range(0, 4))
        0: av_wr(ra, rd, 4'($urandom), 1'b1);
        1: av_rd(ra, 1'b1, 1'b0);
        2: jt_load(ra);
        3: jt_op(1'b1, rd, 1'b1);
        default: jt_op(1'b0, 32'h0, 1'b1);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
